// File: rtl/rep_add_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : rep_add_mac_unit
// Function : Self-sequenced multiply / multiply-accumulate by repeated
//            addition. Start/Busy/Done handshake, abort, sticky overflow
//            with optional saturation.
// Revision : 1.0 - initial release
// ============================================================================
module rep_add_mac_unit #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 8,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic              Clr,
  input  logic              Abort,
  input  logic [DATA_W-1:0] A,
  input  logic [CNT_W-1:0]  B,
  output logic [ACC_W-1:0]  Result,
  output logic              Busy,
  output logic              Done,
  output logic              Ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] c_all_ones = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                ovf_q, ovf_d;

  // One extra bit so the carry out of the accumulator is visible
  logic [ACC_W:0]      w_sum;
  assign w_sum = {1'b0, acc_q} + (ACC_W + 1)'(a_q);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        // Start outranks Clr; a MAC start keeps the current result and flag
        if (Start) begin
          a_d   = A;
          cnt_d = B;
          if (!Mode) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
          state_d = (B == '0) ? S_DONE : S_RUN;
        end else if (Clr) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
      end
      S_RUN: begin
        if (Abort) begin
          // Partial result is kept, no completion pulse
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
          if (w_sum[ACC_W]) begin
            ovf_d = 1'b1;
            acc_d = (SATURATE != 0) ? c_all_ones : w_sum[ACC_W-1:0];
          end else begin
            acc_d = w_sum[ACC_W-1:0];
          end
          if (cnt_q == c_cnt_one) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Result = acc_q;
  assign Busy   = (state_q == S_RUN);
  assign Done   = (state_q == S_DONE);
  assign Ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rep_add_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rep_add_mac_unit
// Function : Self-checking bench for rep_add_mac_unit (wrapping and
//            saturating instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rep_add_mac_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Mode = 1'b0;
  logic        Clr = 1'b0;
  logic        Abort = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] res_w, res_s;
  logic        busy_w, busy_s, done_w, done_s, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  // Reference state: expected result/flag of each instance
  longint exp_w = 0, exp_s = 0;
  bit     eov_w = 0, eov_s = 0;

  always #5 Clk = ~Clk;

  rep_add_mac_unit #(.DATA_W(8), .CNT_W(8), .ACC_W(16), .SATURATE(0)) u_dut_wrap (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Clr(Clr), .Abort(Abort),
    .A(A), .B(B), .Result(res_w), .Busy(busy_w), .Done(done_w), .Ovf(ovf_w)
  );

  rep_add_mac_unit #(.DATA_W(8), .CNT_W(8), .ACC_W(16), .SATURATE(1)) u_dut_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Clr(Clr), .Abort(Abort),
    .A(A), .B(B), .Result(res_s), .Busy(busy_s), .Done(done_s), .Ovf(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_res_wrap"}, 32'(res_w), 32'(exp_w));
    chk({tag, "_res_sat"},  32'(res_s), 32'(exp_s));
    chk({tag, "_ovf_wrap"}, 32'(ovf_w), 32'(eov_w));
    chk({tag, "_ovf_sat"},  32'(ovf_s), 32'(eov_s));
  endtask

  // Result of a full transaction: base + a*b, wrapped or clamped
  task automatic model_txn(input bit mode, input int a, input int b);
    longint tw, ts;
    tw = (mode ? exp_w : 0) + longint'(a) * b;
    ts = (mode ? exp_s : 0) + longint'(a) * b;
    eov_w = (mode && eov_w) || (tw > 65535);
    eov_s = (mode && eov_s) || (ts > 65535);
    exp_w = tw % 65536;
    exp_s = (ts > 65535) ? 65535 : ts;
  endtask

  // One Start..Done transaction with latency, Busy and result checks
  task automatic run_txn(input bit mode, input int a, input int b, input bit clr);
    int n, busy_cnt;
    @(negedge Clk);
    Start = 1'b1; Mode = mode; A = 8'(a); B = 8'(b); Clr = clr;
    @(negedge Clk);
    // Scramble the operands after E0; they must already be latched
    Start = 1'b0; Clr = 1'b0;
    Mode = 1'($urandom); A = 8'($urandom); B = 8'($urandom);
    n = 0; busy_cnt = 0;
    while (done_w !== 1'b1 && n < b + 4) begin
      if (busy_w === 1'b1 && busy_s === 1'b1) busy_cnt++;
      @(negedge Clk);
      n++;
    end
    model_txn(mode, a, b);
    chk("done_latency", 32'(n), 32'(b));
    chk("busy_cycles", 32'(busy_cnt), 32'(b));
    chk("done_sat", 32'(done_s), 32'd1);
    chk_state("at_done");
    @(negedge Clk);
    chk("done_pulse_end", 32'({done_w, done_s, busy_w, busy_s}), 32'd0);
  endtask

  task automatic do_clr();
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    exp_w = 0; exp_s = 0; eov_w = 0; eov_s = 0;
    chk_state("clr");
  endtask

  initial begin
    bit saw_done;
    // Reset state
    #3;
    chk("rst_busy_done", 32'({busy_w, busy_s, done_w, done_s}), 32'd0);
    chk_state("reset");
    @(negedge Clk);
    Reset = 1'b1;

    // Basic multiply, MAC, clear
    run_txn(1'b0, 5, 3, 1'b0);     // 15
    run_txn(1'b1, 7, 2, 1'b0);     // 29
    do_clr();

    // Zero repeat count
    run_txn(1'b0, 9, 0, 1'b0);     // 0
    run_txn(1'b0, 29, 1, 1'b0);    // 29
    run_txn(1'b1, 9, 0, 1'b0);     // stays 29

    // Maximum count and overflow
    run_txn(1'b0, 255, 255, 1'b0); // 65025
    run_txn(1'b1, 255, 255, 1'b0); // wrap 64514 / sat 65535, Ovf set
    do_clr();

    // Abort after the second add; Start during RUN is ignored
    saw_done = 1'b0;
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b0; A = 8'd10; B = 8'd5;
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b1; A = 8'd99; B = 8'd1;
    saw_done |= done_w | done_s;
    @(negedge Clk);
    Start = 1'b0;
    saw_done |= done_w | done_s;
    @(negedge Clk);
    Abort = 1'b1;
    saw_done |= done_w | done_s;
    @(negedge Clk);
    Abort = 1'b0;
    saw_done |= done_w | done_s;
    exp_w = 20; exp_s = 20; eov_w = 0; eov_s = 0;
    chk("abort_busy", 32'({busy_w, busy_s}), 32'd0);
    chk_state("abort");
    repeat (3) begin
      @(negedge Clk);
      saw_done |= done_w | done_s;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_hold", 32'(res_w), 32'd20);

    // Asynchronous reset in the middle of a long run
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b0; A = 8'd3; B = 8'd100;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    exp_w = 0; exp_s = 0; eov_w = 0; eov_s = 0;
    chk("arst_busy_done", 32'({busy_w, busy_s, done_w, done_s}), 32'd0);
    chk_state("arst");
    @(negedge Clk);
    chk("arst_held", 32'({busy_w, busy_s, done_w, done_s}), 32'd0);
    Reset = 1'b1;
    run_txn(1'b0, 3, 4, 1'b0);     // 12

    // Randomized transactions against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      int a, b;
      bit m, c;
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
      m = 1'($urandom);
      c = ($urandom_range(0, 3) == 0);
      run_txn(m, a, b, c);
      if ($urandom_range(0, 5) == 0) do_clr();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
